// File: rtl/mac_axi_buf_pkg.sv
// Shared types, register map and helpers for the
// MAC RX packet ring buffer.
package mac_axi_buf_pkg;

  localparam int PKG_DATA_W = 32;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_SOP,
    W_WR,
    W_DROP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_MEM,
    R_RESP
  } rd_state_e;

  localparam logic [15:0] STATUS     = 16'h0000;
  localparam logic [15:0] HEAD_LEN   = 16'h0004;
  localparam logic [15:0] PKT_COUNT  = 16'h0008;
  localparam logic [15:0] DROP_COUNT = 16'h000C;
  localparam logic [15:0] RELEASE    = 16'h0010;
  localparam logic [15:0] DATA_BASE  = 16'h8000;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

  function automatic logic [PKG_DATA_W-1:0] ben_to_mask(
    input logic [7:0] ben
  );
    logic [PKG_DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < PKG_DATA_W / 8; b++) begin
      if (b <= int'(ben)) m[b*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/pkt_slot_ram.sv
// Simple dual-port slot memory, one write port and
// one registered read port.
module pkt_slot_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mac_rx_pkt_ring_buffer.sv
// Multi-slot MAC RX frame buffer drained through an
// AXI4-Lite read-only register/data window.
module mac_rx_pkt_ring_buffer
  import mac_axi_buf_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BEN_W       = 2,
  parameter int SLOT_CNT    = 4,
  parameter int SLOT_ADDR_W = 9,
  parameter int AXI_ADDR_W  = 32
) (
  input  logic                  mac_clk_i,
  input  logic                  ARESETN,
  input  logic [DATA_W-1:0]     mac_rxd_i,
  input  logic [BEN_W-1:0]      mac_ben_i,
  input  logic                  mac_rxda_i,
  input  logic                  mac_rxsop_i,
  input  logic                  mac_rxeop_i,
  input  logic                  mac_rxdv_i,
  output logic                  mac_rxrqrd_o,
  input  logic [AXI_ADDR_W-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_W-1:0]     S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  localparam int SLOT_W = $clog2(SLOT_CNT);
  localparam int OCC_W  = SLOT_W + 1;
  localparam int IDX_W  = SLOT_ADDR_W + 1;
  localparam int RAM_AW = SLOT_W + SLOT_ADDR_W;
  localparam int NB     = DATA_W / 8;
  localparam int WA_W   = AXI_ADDR_W - 2;

  wr_state_e r_wst, w_wst_nxt;
  rd_state_e r_rst, w_rst_nxt;

  logic              r_rqrd;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [SLOT_W-1:0] r_wr_slot, r_rd_slot;
  logic [OCC_W-1:0]  r_occ;
  logic [31:0]       r_pkt_cnt, r_drop_cnt;
  logic [31:0]       r_len [SLOT_CNT];

  logic w_we, w_commit, w_drop_inc, w_pop;
  logic w_full, w_empty;

  logic [DATA_W-1:0]      w_mask, w_wdata;
  logic [SLOT_ADDR_W-1:0] w_widx;
  logic [31:0]            w_len;
  logic [DATA_W-1:0]      w_ram_q;

  logic              r_arready, r_rvalid, r_rel;
  logic [DATA_W-1:0] r_rdata, w_rd;
  logic [1:0]        r_rresp, w_rr;
  logic              w_rel;
  logic [WA_W-1:0]   r_waddr;
  logic [12:0]       w_k;
  logic w_is_stat, w_is_len, w_is_pkt;
  logic w_is_drop, w_is_rel, w_is_data, w_k_ok;
  logic w_unused;

  assign w_full  = (r_occ == OCC_W'(SLOT_CNT));
  assign w_empty = (r_occ == '0);

  assign w_mask = DATA_W'(ben_to_mask(8'(mac_ben_i)));
  assign w_wdata = mac_rxeop_i ? (mac_rxd_i & w_mask)
                               : mac_rxd_i;
  assign w_widx = (r_wst == W_WAIT_SOP) ? '0
                : r_idx[SLOT_ADDR_W-1:0];
  assign w_len = 32'(w_idx_nxt) * 32'(NB)
               - 32'(NB - 1) + 32'(mac_ben_i);

  always_comb begin
    w_wst_nxt  = r_wst;
    w_idx_nxt  = r_idx;
    w_we       = 1'b0;
    w_commit   = 1'b0;
    w_drop_inc = 1'b0;
    unique case (r_wst)
      W_IDLE: begin
        if (mac_rxda_i && !w_full) w_wst_nxt = W_WAIT_SOP;
      end
      W_WAIT_SOP: begin
        if (mac_rxdv_i && mac_rxsop_i) begin
          w_we      = 1'b1;
          w_idx_nxt = IDX_W'(1);
          if (mac_rxeop_i) begin
            w_commit  = 1'b1;
            w_wst_nxt = W_IDLE;
          end else begin
            w_wst_nxt = W_WR;
          end
        end
      end
      W_WR: begin
        if (mac_rxdv_i) begin
          if (mac_rxsop_i) begin
            w_wst_nxt = W_DROP;
          end else if (r_idx[SLOT_ADDR_W]) begin
            // slot already full: this word overflows it
            if (mac_rxeop_i) begin
              w_drop_inc = 1'b1;
              w_wst_nxt  = W_IDLE;
            end else begin
              w_wst_nxt = W_DROP;
            end
          end else begin
            w_we      = 1'b1;
            w_idx_nxt = r_idx + 1'b1;
            if (mac_rxeop_i) begin
              w_commit  = 1'b1;
              w_wst_nxt = W_IDLE;
            end
          end
        end
      end
      W_DROP: begin
        if (mac_rxdv_i && mac_rxeop_i) begin
          w_drop_inc = 1'b1;
          w_wst_nxt  = W_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge mac_clk_i) begin
    if (!ARESETN) begin
      r_wst      <= W_IDLE;
      r_rqrd     <= 1'b0;
      r_idx      <= '0;
      r_wr_slot  <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_wst  <= w_wst_nxt;
      r_rqrd <= (w_wst_nxt != W_IDLE) && mac_rxda_i;
      r_idx  <= (w_wst_nxt == W_IDLE) ? '0 : w_idx_nxt;
      if (w_commit) begin
        r_wr_slot <= r_wr_slot + 1'b1;
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge mac_clk_i) begin
    if (w_commit) r_len[r_wr_slot] <= w_len;
  end

  assign w_pop = (r_rst == R_RESP) && S_AXI_RREADY && r_rel;

  always_ff @(posedge mac_clk_i) begin
    if (!ARESETN) begin
      r_occ     <= '0;
      r_rd_slot <= '0;
    end else begin
      if (w_pop) r_rd_slot <= r_rd_slot + 1'b1;
      if (w_commit && !w_pop) r_occ <= r_occ + 1'b1;
      if (!w_commit && w_pop) r_occ <= r_occ - 1'b1;
    end
  end

  pkt_slot_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (RAM_AW)
  ) u_ram (
    .i_clk   (mac_clk_i),
    .i_we    (w_we),
    .i_waddr ({r_wr_slot, w_widx}),
    .i_wdata (w_wdata),
    .i_raddr ({r_rd_slot,
               S_AXI_ARADDR[SLOT_ADDR_W+1:2]}),
    .o_rdata (w_ram_q)
  );

  assign w_is_stat = (r_waddr == WA_W'(STATUS >> 2));
  assign w_is_len  = (r_waddr == WA_W'(HEAD_LEN >> 2));
  assign w_is_pkt  = (r_waddr == WA_W'(PKT_COUNT >> 2));
  assign w_is_drop = (r_waddr == WA_W'(DROP_COUNT >> 2));
  assign w_is_rel  = (r_waddr == WA_W'(RELEASE >> 2));
  assign w_is_data = (r_waddr[WA_W-1:13]
                      == (WA_W-13)'(DATA_BASE >> 15));
  assign w_k       = r_waddr[12:0];
  assign w_k_ok    = (32'(w_k) < (32'd1 << SLOT_ADDR_W));
  assign w_unused  = ^S_AXI_ARADDR[1:0];

  always_comb begin
    w_rd  = '0;
    w_rr  = RRESP_SLVERR;
    w_rel = 1'b0;
    unique case (1'b1)
      w_is_stat: begin
        w_rd = DATA_W'({14'd0, w_empty, w_full,
                        8'(r_rd_slot), 8'(r_occ)});
        w_rr = RRESP_OKAY;
      end
      w_is_len: begin
        if (!w_empty) begin
          w_rd = DATA_W'(r_len[r_rd_slot]);
          w_rr = RRESP_OKAY;
        end
      end
      w_is_pkt: begin
        w_rd = DATA_W'(r_pkt_cnt);
        w_rr = RRESP_OKAY;
      end
      w_is_drop: begin
        w_rd = DATA_W'(r_drop_cnt);
        w_rr = RRESP_OKAY;
      end
      w_is_rel: begin
        if (!w_empty) begin
          w_rd  = DATA_W'(r_len[r_rd_slot]);
          w_rr  = RRESP_OKAY;
          w_rel = 1'b1;
        end
      end
      w_is_data: begin
        if (!w_empty && w_k_ok) begin
          w_rd = w_ram_q;
          w_rr = RRESP_OKAY;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rst_nxt = r_rst;
    unique case (r_rst)
      R_IDLE: if (S_AXI_ARVALID && r_arready)
                w_rst_nxt = R_MEM;
      R_MEM:  w_rst_nxt = R_RESP;
      R_RESP: if (S_AXI_RREADY) w_rst_nxt = R_IDLE;
      default: w_rst_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge mac_clk_i) begin
    if (!ARESETN) begin
      r_rst     <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RRESP_OKAY;
      r_rel     <= 1'b0;
      r_waddr   <= '0;
    end else begin
      r_rst     <= w_rst_nxt;
      r_arready <= (w_rst_nxt == R_IDLE);
      if (r_rst == R_IDLE && S_AXI_ARVALID && r_arready)
        r_waddr <= S_AXI_ARADDR[AXI_ADDR_W-1:2];
      if (r_rst == R_MEM) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd;
        r_rresp  <= w_rr;
        r_rel    <= w_rel;
      end else if (r_rst == R_RESP && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
        r_rel    <= 1'b0;
      end
    end
  end

  assign mac_rxrqrd_o  = r_rqrd;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_mac_rx_pkt_ring_buffer.sv
// Directed bench for mac_rx_pkt_ring_buffer: register
// table checks plus multi-cycle corner sequences.
module tb_mac_rx_pkt_ring_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] rxd;
  logic [1:0]  ben;
  logic        rxda, sop, eop, dv;
  logic        rqrd;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  mac_rx_pkt_ring_buffer dut (
    .mac_clk_i     (clk),
    .ARESETN       (rstn),
    .mac_rxd_i     (rxd),
    .mac_ben_i     (ben),
    .mac_rxda_i    (rxda),
    .mac_rxsop_i   (sop),
    .mac_rxeop_i   (eop),
    .mac_rxdv_i    (dv),
    .mac_rxrqrd_o  (rqrd),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;

  vec_t tab[11];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic ar_send(input logic [31:0] a);
    int t;
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!arready) chk("arready_timeout", 0, 1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic r_wait(output int lat);
    lat = 1;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rvalid) chk("rvalid_timeout", 0, 1);
  endtask

  task automatic r_take();
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d,
                    output logic [1:0] r,
                    output int lat);
    ar_send(a);
    r_wait(lat);
    d = rdata;
    r = rresp;
    r_take();
  endtask

  task automatic rd_chk(input string nm,
                        input logic [31:0] a,
                        input logic [31:0] ed,
                        input logic [1:0] er);
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    rd(a, d, r, lat);
    chk(nm, {30'd0, r, d}, {30'd0, er, ed});
  endtask

  task automatic send_frame(input int n,
                            input logic [31:0] base,
                            input logic [31:0] last,
                            input logic [1:0] b);
    int t;
    @(negedge clk);
    rxda = 1'b1;
    t = 0;
    while (!rqrd && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rqrd) begin
      chk("rqrd_timeout", 0, 1);
    end else begin
      for (int i = 0; i < n; i++) begin
        rxd = (i == n - 1) ? last : base + 32'(i);
        sop = (i == 0);
        eop = (i == n - 1);
        ben = b;
        dv  = 1'b1;
        @(negedge clk);
      end
    end
    dv   = 1'b0;
    sop  = 1'b0;
    eop  = 1'b0;
    rxda = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat, t;
    logic        seen;

    rstn = 1'b0; rxd = '0; ben = '0; rxda = 1'b0;
    sop = 1'b0; eop = 1'b0; dv = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    repeat (4) @(negedge clk);
    chk("rst_rqrd", rqrd, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata_rresp", {rresp, rdata}, 0);
    rstn = 1'b1;

    rd(32'h0, d, r, lat);
    chk("status_empty", {r, d}, {2'b00, 32'h00020000});
    chk("read_latency", lat, 2);

    rd_chk("release_empty", 32'h10, 32'h0, 2'b10);
    rd_chk("status_after_rel_empty", 32'h0,
           32'h00020000, 2'b00);

    send_frame(3, 32'h11111111, 32'hAABBCCDD, 2'b01);
    tab[0]  = '{"t_status",   32'h0000, 32'h00000001, 2'b00};
    tab[1]  = '{"t_head_len", 32'h0004, 32'd10,       2'b00};
    tab[2]  = '{"t_pkt_cnt",  32'h0008, 32'd1,        2'b00};
    tab[3]  = '{"t_drop_cnt", 32'h000C, 32'd0,        2'b00};
    tab[4]  = '{"t_word0",    32'h8000, 32'h11111111, 2'b00};
    tab[5]  = '{"t_word1",    32'h8004, 32'h11111112, 2'b00};
    tab[6]  = '{"t_word2_msk",32'h8008, 32'h0000CCDD, 2'b00};
    tab[7]  = '{"t_win_oob",  32'h9000, 32'h0,        2'b10};
    tab[8]  = '{"t_k512",     32'h8800, 32'h0,        2'b10};
    tab[9]  = '{"t_bad_addr", 32'h0014, 32'h0,        2'b10};
    tab[10] = '{"t_low_bits", 32'h0007, 32'd10,       2'b00};
    for (int i = 0; i < 11; i++) begin
      rd_chk(tab[i].nm, tab[i].addr,
             tab[i].data, tab[i].resp);
    end

    rd_chk("release_first", 32'h10, 32'd10, 2'b00);
    rd_chk("status_rd1", 32'h0, 32'h00020100, 2'b00);

    send_frame(1, 32'h0, 32'h01010101, 2'd3);
    send_frame(1, 32'h0, 32'hDEADBEEF, 2'd0);
    send_frame(1, 32'h0, 32'h03030303, 2'd1);
    send_frame(1, 32'h0, 32'h04040404, 2'd2);
    rd_chk("status_full", 32'h0, 32'h00010104, 2'b00);

    @(negedge clk);
    rxda = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= rqrd;
    end
    chk("full_backpressure", seen, 0);
    rd_chk("release_full", 32'h10, 32'd4, 2'b00);
    send_frame(1, 32'h0, 32'h05050505, 2'd0);
    rd_chk("status_refull", 32'h0, 32'h00010204, 2'b00);
    rd_chk("pkt_cnt_6", 32'h8, 32'd6, 2'b00);
    rd_chk("masked_ben0", 32'h8000, 32'h000000EF, 2'b00);
    rd_chk("rel_len1", 32'h10, 32'd1, 2'b00);
    rd_chk("rel_len2", 32'h10, 32'd2, 2'b00);
    rd_chk("rel_len3", 32'h10, 32'd3, 2'b00);
    rd_chk("rel_len4", 32'h10, 32'd1, 2'b00);
    rd_chk("status_drained", 32'h0, 32'h00020200, 2'b00);

    send_frame(513, 32'h10000000, 32'h10000200, 2'd3);
    rd_chk("drop_cnt", 32'hC, 32'd1, 2'b00);
    rd_chk("status_after_drop", 32'h0,
           32'h00020200, 2'b00);
    send_frame(2, 32'h55550000, 32'h12345678, 2'd3);
    rd_chk("status_same_slot", 32'h0,
           32'h00000201, 2'b00);
    rd_chk("same_slot_w0", 32'h8000, 32'h55550000, 2'b00);
    rd_chk("same_slot_w1", 32'h8004, 32'h12345678, 2'b00);
    rd_chk("pkt_cnt_7", 32'h8, 32'd7, 2'b00);

    @(negedge clk);
    rxda = 1'b1;
    t = 0;
    while (!rqrd && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("coinc_rqrd", rqrd, 1);
    rxd = 32'h0BADF00D; sop = 1'b1; dv = 1'b1;
    @(negedge clk);
    dv = 1'b0; sop = 1'b0;
    ar_send(32'h10);
    r_wait(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rdata_hold", {rvalid, rresp, rdata},
          {1'b1, 2'b00, 32'd8});
    end
    rready = 1'b1;
    rxd = 32'hCAFEF00D; eop = 1'b1; ben = 2'd2; dv = 1'b1;
    @(negedge clk);
    rready = 1'b0; dv = 1'b0; eop = 1'b0; rxda = 1'b0;
    rd_chk("coinc_status", 32'h0, 32'h00000301, 2'b00);
    rd_chk("coinc_len", 32'h4, 32'd7, 2'b00);
    rd_chk("coinc_w0", 32'h8000, 32'h0BADF00D, 2'b00);
    rd_chk("coinc_w1", 32'h8004, 32'h00FEF00D, 2'b00);

    send_frame(1, 32'h0, 32'h77777777, 2'd3);
    rd_chk("rel_coinc", 32'h10, 32'd7, 2'b00);
    rd_chk("status_wrap", 32'h0, 32'h00000001, 2'b00);
    rd_chk("wr_slot_wrap", 32'h8000, 32'h77777777, 2'b00);
    rd_chk("pkt_cnt_9", 32'h8, 32'd9, 2'b00);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
